// File: rtl/result_readback_if.sv
// result_readback_if: SRAM read port and output word stream of the result readback engine
//   master (engine side): drives sram_re/sram_raddr and out_valid/out_data/out_last, takes sram_rdata/out_ready
//   slave  (SRAM + host side): the mirror image
interface result_readback_if #(
  parameter int ARRAY_SIZE = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic sram_re;
  logic [ADDR_WIDTH-1:0] sram_raddr;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] sram_rdata;
  logic out_valid;
  logic out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic out_last;
  modport master(output sram_re, sram_raddr, out_valid, out_data, out_last, input sram_rdata, out_ready);
  modport slave(input sram_re, sram_raddr, out_valid, out_data, out_last, output sram_rdata, out_ready);
endinterface

// File: rtl/result_readback.sv
// result_readback: drains result SRAM lines and serializes them into a word stream
//   clk, srstn (async, active-low), start/line_count job request, busy/done job status,
//   bus: SRAM read port (sram_re, sram_raddr, sram_rdata) and stream (out_valid, out_ready, out_data, out_last)
module result_readback #(
  parameter int ARRAY_SIZE = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic clk,
  input  logic srstn,
  input  logic start,
  input  logic [ADDR_WIDTH:0] line_count,
  output logic busy,
  output logic done,
  result_readback_if.master bus
);
  localparam logic [2:0] IDLE = 3'd0, REQ = 3'd1, WAIT = 3'd2, SEND = 3'd3, DONE = 3'd4;
  localparam int WW = $clog2(ARRAY_SIZE);
  logic [2:0] state;
  logic [ADDR_WIDTH:0] lines_q;
  logic [ADDR_WIDTH-1:0] line_ptr;
  logic [WW-1:0] word_idx;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] line_buf;
  logic more, xfer, last_word;
  // the all-ones test keeps an oversized line_count from wrapping the address
  assign more = ({1'b0, line_ptr} + 1'b1 < lines_q) && !(&line_ptr);
  assign xfer = bus.out_valid && bus.out_ready;
  assign last_word = word_idx == WW'(ARRAY_SIZE - 1);
  always_ff @(posedge clk or negedge srstn)
    if (!srstn) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      bus.sram_re <= 1'b0;
      bus.sram_raddr <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.out_last <= 1'b0;
      lines_q <= '0;
      line_ptr <= '0;
      word_idx <= '0;
      line_buf <= '0;
    end else begin
      done <= 1'b0;
      bus.sram_re <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy <= 1'b1;
          lines_q <= line_count;
          line_ptr <= '0;
          bus.sram_raddr <= '0;
          bus.sram_re <= line_count != '0;
          done <= line_count == '0;
          state <= line_count == '0 ? DONE : REQ;
        end
        REQ: state <= WAIT;
        WAIT: begin
          line_buf <= bus.sram_rdata;
          word_idx <= '0;
          bus.out_valid <= 1'b1;
          bus.out_data <= bus.sram_rdata[DATA_WIDTH-1:0];
          bus.out_last <= 1'b0;
          state <= SEND;
        end
        SEND: if (xfer) begin
          if (last_word) begin
            bus.out_valid <= 1'b0;
            bus.out_last <= 1'b0;
            line_ptr <= more ? line_ptr + 1'b1 : line_ptr;
            bus.sram_raddr <= more ? line_ptr + 1'b1 : bus.sram_raddr;
            bus.sram_re <= more;
            done <= !more;
            state <= more ? REQ : DONE;
          end else begin
            // next word is prepared here so out_data stays a registered output
            word_idx <= word_idx + 1'b1;
            bus.out_data <= line_buf[(32'(word_idx) + 1) * DATA_WIDTH +: DATA_WIDTH];
            bus.out_last <= (word_idx == WW'(ARRAY_SIZE - 2)) && !more;
          end
        end
        DONE: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  always_ff @(posedge clk)
    if (srstn && state == IDLE && start)
      assert (line_count <= (ADDR_WIDTH + 1)'(ARRAY_SIZE));
endmodule
